// File: rtl/seg7_pair_decoder.sv
// Recovers the 0-99 value shown on an active-low two-digit seven-segment pair,
// debouncing the pattern and reporting each new stable pair once via valid/ready.
module seg7_pair_decoder #(
  parameter int unsigned STABLE_CYCLES = 4
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [6:0] HEX0,
  input  logic [6:0] HEX1,
  input  logic       ready,
  output logic [6:0] num,
  output logic       valid,
  output logic       error
);

  localparam logic [3:0] CNT_MAX = 4'(STABLE_CYCLES - 1);

  typedef enum logic [0:0] {IDLE = 1'b0, HOLD = 1'b1} state_t;

  // {legal, digit}; blank and every non-digit pattern are illegal on the ones side
  function automatic logic [4:0] decode_ones(input logic [6:0] seg);
    logic [4:0] res;
    case (seg)
      7'b1000000: res = {1'b1, 4'd0};
      7'b1111001: res = {1'b1, 4'd1};
      7'b0100100: res = {1'b1, 4'd2};
      7'b0110000: res = {1'b1, 4'd3};
      7'b0011001: res = {1'b1, 4'd4};
      7'b0010010: res = {1'b1, 4'd5};
      7'b0000010: res = {1'b1, 4'd6};
      7'b1111000: res = {1'b1, 4'd7};
      7'b0000000: res = {1'b1, 4'd8};
      7'b0010000: res = {1'b1, 4'd9};
      default:    res = {1'b0, 4'd0};
    endcase
    return res;
  endfunction

  // Tens digit: blank means 0, an explicit leading zero is illegal
  function automatic logic [4:0] decode_tens(input logic [6:0] seg);
    logic [4:0] res;
    case (seg)
      7'b1111111: res = {1'b1, 4'd0};
      7'b1000000: res = {1'b0, 4'd0};
      default:    res = decode_ones(seg);
    endcase
    return res;
  endfunction

  logic [13:0] pair_q, pair_d;
  logic [13:0] last_q, last_d;
  logic        reported_q, reported_d;
  logic [3:0]  cnt_q, cnt_d;
  state_t      state_q, state_d;
  logic [6:0]  num_q, num_d;
  logic        valid_q, valid_d;
  logic        error_q, error_d;

  logic [13:0] in_pair_s;
  logic [4:0]  tens_s;
  logic [4:0]  ones_s;
  logic        legal_s;
  logic        stable_s;
  logic [6:0]  value_s;

  // Next-state logic: sampling, stability counter and report FSM
  always_comb begin
    in_pair_s = {HEX1, HEX0};
    pair_d    = in_pair_s;
    if (in_pair_s == pair_q) begin
      cnt_d = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + 4'd1;
    end else begin
      cnt_d = 4'd0;
    end

    tens_s   = decode_tens(pair_q[13:7]);
    ones_s   = decode_ones(pair_q[6:0]);
    legal_s  = tens_s[4] & ones_s[4];
    value_s  = ({3'd0, tens_s[3:0]} * 7'd10) + {3'd0, ones_s[3:0]};
    stable_s = (cnt_q == CNT_MAX) && (!reported_q || (pair_q != last_q));

    state_d    = state_q;
    num_d      = num_q;
    valid_d    = valid_q;
    error_d    = 1'b0;
    last_d     = last_q;
    reported_d = reported_q;

    case (state_q)
      IDLE: begin
        if (stable_s) begin
          last_d     = pair_q;
          reported_d = 1'b1;
          if (legal_s) begin
            num_d   = value_s;
            valid_d = 1'b1;
            state_d = HOLD;
          end else begin
            error_d = 1'b1;
          end
        end else begin
          valid_d = 1'b0;
        end
      end
      HOLD: begin
        if (valid_q && ready) begin
          valid_d = 1'b0;
          state_d = IDLE;
        end else begin
          valid_d = valid_q;
        end
      end
      default: begin
        state_d = IDLE;
        valid_d = 1'b0;
      end
    endcase
  end

  // State registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pair_q     <= 14'd0;
      last_q     <= 14'd0;
      reported_q <= 1'b0;
      cnt_q      <= 4'd0;
      state_q    <= IDLE;
      num_q      <= 7'd0;
      valid_q    <= 1'b0;
      error_q    <= 1'b0;
    end else begin
      pair_q     <= pair_d;
      last_q     <= last_d;
      reported_q <= reported_d;
      cnt_q      <= cnt_d;
      state_q    <= state_d;
      num_q      <= num_d;
      valid_q    <= valid_d;
      error_q    <= error_d;
    end
  end

  assign num   = num_q;
  assign valid = valid_q;
  assign error = error_q;

endmodule

// File: tb/tb_seg7_pair_decoder.sv
// Directed-vector bench for seg7_pair_decoder with hand-computed expectations.
module tb_seg7_pair_decoder;

  logic       clk = 1'b0;
  logic       reset_n;
  logic [6:0] HEX0;
  logic [6:0] HEX1;
  logic       ready;
  logic [6:0] num;
  logic       valid;
  logic       error;

  int checks = 0;
  int errors = 0;

  localparam logic [6:0] BLANK = 7'b1111111;

  seg7_pair_decoder #(.STABLE_CYCLES(4)) dut (
    .clk(clk), .reset_n(reset_n), .HEX0(HEX0), .HEX1(HEX1),
    .ready(ready), .num(num), .valid(valid), .error(error)
  );

  always #5 clk = ~clk;

  function automatic logic [6:0] seg(input int d);
    case (d)
      0: return 7'b1000000;
      1: return 7'b1111001;
      2: return 7'b0100100;
      3: return 7'b0110000;
      4: return 7'b0011001;
      5: return 7'b0010010;
      6: return 7'b0000010;
      7: return 7'b1111000;
      8: return 7'b0000000;
      9: return 7'b0010000;
      default: return BLANK;
    endcase
  endfunction

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic drive(input logic [6:0] h1, input logic [6:0] h0);
    HEX1 = h1;
    HEX0 = h0;
  endtask

  // Steps until valid or error shows, bounded; returns the step count (0 = none)
  task automatic wait_report(input string tag, output int cyc);
    int n;
    n = 0;
    cyc = 0;
    while (cyc == 0 && n < 30) begin
      step();
      n++;
      if (valid || error) cyc = n;
    end
    check_eq({tag, "_seen"}, (cyc != 0) ? 32'd1 : 32'd0, 32'd1);
  endtask

  initial begin
    int cyc;
    int hits;
    reset_n = 1'b0;
    ready   = 1'b1;
    drive(seg(4), seg(7));
    repeat (2) step();
    check_eq("rst_num", num, 7'd0);
    check_eq("rst_valid", valid, 1'b0);
    check_eq("rst_error", error, 1'b0);

    // Latency from release: first sample at the next edge, valid 4 edges later
    reset_n = 1'b1;
    hits = 0;
    for (int k = 1; k <= 4; k++) begin
      step();
      hits += int'(valid) + int'(error);
    end
    check_eq("lat_early", hits, 0);
    step();
    check_eq("lat47_valid", valid, 1'b1);
    check_eq("lat47_num", num, 7'd47);
    step();
    check_eq("lat47_drop", valid, 1'b0);
    hits = 0;
    repeat (10) begin
      step();
      hits += int'(valid) + int'(error);
    end
    check_eq("no_repeat", hits, 0);

    drive(BLANK, seg(5));
    wait_report("v05", cyc);
    check_eq("v05_lat", cyc, 5);
    check_eq("v05_num", num, 7'd5);
    drive(seg(9), seg(9));
    wait_report("v99", cyc);
    check_eq("v99_valid", valid, 1'b1);
    check_eq("v99_num", num, 7'd99);
    drive(BLANK, seg(0));
    wait_report("v00", cyc);
    check_eq("v00_valid", valid, 1'b1);
    check_eq("v00_num", num, 7'd0);

    // Glitch: alternating 47/48 every 3 cycles never stabilises
    hits = 0;
    for (int i = 0; i < 7; i++) begin
      drive(seg(4), (i % 2 == 1) ? seg(8) : seg(7));
      repeat (3) begin
        step();
        hits += int'(valid) + int'(error);
      end
    end
    check_eq("glitch_quiet", hits, 0);
    drive(seg(4), seg(8));
    wait_report("v48", cyc);
    check_eq("v48_num", num, 7'd48);

    // Leading zero is illegal
    drive(seg(0), seg(0));
    wait_report("ill", cyc);
    check_eq("ill_lat", cyc, 5);
    check_eq("ill_error", error, 1'b1);
    check_eq("ill_valid", valid, 1'b0);
    check_eq("ill_num", num, 7'd48);
    hits = 0;
    repeat (8) begin
      step();
      hits += int'(valid) + int'(error);
    end
    check_eq("ill_single", hits, 0);

    // Backpressure
    ready = 1'b0;
    drive(seg(1), seg(2));
    wait_report("v12", cyc);
    check_eq("v12_num", num, 7'd12);
    drive(seg(3), seg(4));
    hits = 0;
    repeat (10) begin
      step();
      if (!valid || num != 7'd12) hits++;
    end
    check_eq("bp_hold", hits, 0);
    ready = 1'b1;
    step();
    check_eq("bp_drop", valid, 1'b0);
    step();
    check_eq("v34_valid", valid, 1'b1);
    check_eq("v34_num", num, 7'd34);
    step();
    check_eq("v34_drop", valid, 1'b0);

    // Asynchronous reset in the middle of a pending handshake
    ready = 1'b0;
    drive(seg(5), seg(6));
    wait_report("v56", cyc);
    check_eq("v56_num", num, 7'd56);
    #2 reset_n = 1'b0;
    #1;
    check_eq("arst_valid", valid, 1'b0);
    check_eq("arst_num", num, 7'd0);
    check_eq("arst_error", error, 1'b0);
    @(negedge clk);
    reset_n = 1'b1;
    wait_report("rel56", cyc);
    check_eq("rel56_lat", cyc, 5);
    check_eq("rel56_num", num, 7'd56);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/seg7_pair_decoder.md
# seg7_pair_decoder

Reads back a two-digit active-low seven-segment display pair (tens on HEX1, ones on HEX0) and recovers the unsigned decimal value 0–99 it shows. It sits on the capture side of the display path. It filters transient patterns with a stability counter, reports each new stable value once through a valid/ready handshake, and flags stable patterns that are not legal two-digit displays.

## Interface
- STABLE_CYCLES, 4, number of consecutive identical samples required before a pattern pair is reported; legal range 2–15.
- clk  input  1  single clock; all state updates on the rising edge.
- reset_n  input  1  asynchronous, active-low reset.
- HEX0  input  7  ones-digit segments, bit 6..0 = segments g..a, active-low (0 = lit).
- HEX1  input  7  tens-digit segments, same encoding.
- num  output  7  decoded value, 0–99.
- valid  output  1  num holds a new value; held until accepted.
- ready  input  1  consumer accepts num when valid && ready at a clock edge.
- error  output  1  one-cycle pulse: a stable, illegal pattern pair was seen.

## Operation
- Legal ones patterns (HEX0, active-low): 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000. Any other value, including blank 1111111, is illegal.
- Legal tens patterns (HEX1): blank 1111111 = tens 0; digits 1–9 use the same patterns as the ones digit. The zero pattern 1000000 on HEX1 is illegal because leading zeros are never displayed.
- num = tens*10 + ones, computed at 7 bits with a maximum of 99.
- Sampling: pair_q <= {HEX1,HEX0} every edge. cnt <= (input == pair_q) ? sat_inc(cnt) : 0, with cnt saturating at STABLE_CYCLES-1.
- Stable condition: cnt == STABLE_CYCLES-1, and either no pair has been reported since reset or pair_q differs from last_q (the last reported pair, legal or illegal).
- FSM states: IDLE and HOLD.
  - IDLE, stable, legal: register num, set valid, set last_q <= pair_q, go to HOLD.
  - IDLE, stable, illegal: pulse error for 1 cycle, set last_q <= pair_q, leave num unchanged, stay in IDLE.
  - HOLD: num and valid are frozen. When valid && ready at an edge, clear valid and go to IDLE.
- Sampling and the counter keep running in HOLD. A pair that becomes stable during HOLD is reported on the first IDLE cycle, because its condition still holds there. Intermediate pairs that were stable but superseded during HOLD are lost.
- The same pair is never reported twice in a row. It is reported again only after a different pair has been reported in between.

## Timing
- Reset (asynchronous, immediate): num=0, valid=0, error=0, cnt=0, pair_q=0, FSM=IDLE, "reported" flag cleared. Assertion mid-handshake aborts it; the pending value is discarded.
- First release: after reset deasserts, the first pair held steady is reported like any new pair, even a blank/illegal one.
- Latency: a pair P first sampled at edge E and held raises valid (or pulses error) at edge E+STABLE_CYCLES. With the default of 4, that is 4 edges.
- A change of either digit at any edge resets cnt to 0 and restarts the latency.
- ready is ignored while valid=0. A valid && ready edge drops valid at that edge. The next report comes no earlier than the following edge.
- error never overlaps a HOLD entry, since both are decided only in IDLE.

## Test plan
- Reset with reset_n=0 mid-stream -> all outputs 0 immediately, no clk edge needed.
- HEX1=0011001, HEX0=1111000 held, ready=1 -> valid rises exactly 4 edges after the first sample with num=47, then drops after 1 cycle. Holding the pattern longer produces no second report.
- HEX1=1111111, HEX0=0010010 -> num=5. Then HEX1=HEX0=0010000 -> num=99. Then HEX1=1111111, HEX0=1000000 -> num=0.
- Glitch: toggle HEX0 between 47 and 48 patterns every 3 cycles for 20 cycles -> no valid and no error. Then hold 48 -> num=48.
- HEX1=1000000, HEX0=1000000 ("00") held -> a single 1-cycle error pulse, valid stays 0, num unchanged.
- Backpressure: report 12 with ready=0, apply 34 and let it stabilise, hold ready=0 for 10 cycles -> num stays 12. Raise ready -> valid drops, next cycle valid=1 with num=34.
